// File: rtl/spram_arbiter.sv
// spram_arbiter: shares the single-port SPRAM data memory between the core
// data port (m0) and the loader/DMA port (m1). One RAM access per cycle,
// read results are steered back to the issuing port one cycle later, and
// out-of-range accesses are accepted but dropped and flagged on mN_err.
// Build option: define SPRAM_ARB_FIXED_PRIO_EN for fixed priority
// (port 0 always wins, no lock support); default is round-robin with a
// bounded lock.
module spram_arbiter #(
   parameter int WORDS    = 32768,
   parameter int AW       = 15,
   parameter int MAX_LOCK = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [3:0]    m0_be,
   input  logic [31:0]   m0_addr,
   input  logic [31:0]   m0_wdata,
   input  logic          m0_lock,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [31:0]   m0_rdata,
   output logic          m0_err,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [3:0]    m1_be,
   input  logic [31:0]   m1_addr,
   input  logic [31:0]   m1_wdata,
   input  logic          m1_lock,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [31:0]   m1_rdata,
   output logic          m1_err,
   output logic [AW-1:0] ram_addr,
   output logic [3:0]    ram_wen,
   output logic [31:0]   ram_wdata,
   input  logic [31:0]   ram_rdata
);

   // First byte address past the end of the RAM.
   localparam logic [31:0] ADDR_LIMIT = 32'(4 * WORDS);

   logic        win;        // selected port index (0 or 1)
   logic        accept;     // an access is accepted this cycle
   logic        w_we;
   logic [3:0]  w_be;
   logic [31:0] w_addr;
   logic [31:0] w_wdata;
   logic        in_range;

   logic        rd_pending_q, rd_pending_d;
   logic        rd_owner_q, rd_owner_d;
   logic        rd_oob_q, rd_oob_d;
   logic [1:0]  err_q, err_d;

`ifdef SPRAM_ARB_FIXED_PRIO_EN
   // Fixed priority: port 0 wins whenever it requests.
   always_comb begin
      win = ~m0_req & m1_req;
   end
`else
   localparam int CW = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK - 1);

   logic          last_owner_q, last_owner_d;
   logic [CW-1:0] lock_cnt_q, lock_cnt_d;
   logic          owner_lock;
   logic          win_lock;

   // Round-robin on ties; a locked last owner keeps priority until the
   // counter reaches MAX_LOCK-1, after which the other port gets a turn.
   always_comb begin
      owner_lock   = last_owner_q ? m1_lock : m0_lock;
      win          = 1'b0;
      if (m0_req && m1_req) begin
         if (owner_lock && (lock_cnt_q < CNT_MAX))
            win = last_owner_q;
         else
            win = ~last_owner_q;
      end else if (m1_req) begin
         win = 1'b1;
      end
      win_lock     = win ? m1_lock : m0_lock;
      last_owner_d = last_owner_q;
      lock_cnt_d   = lock_cnt_q;
      if (m0_req || m1_req) begin
         last_owner_d = win;
         if ((win != last_owner_q) || !win_lock)
            lock_cnt_d = '0;
         else if (lock_cnt_q < CNT_MAX)
            lock_cnt_d = lock_cnt_q + 1'b1;
      end else if (!owner_lock) begin
         lock_cnt_d = '0;
      end
   end

   // Round-robin pointer and lock counter; port 0 wins the first tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_owner_q <= 1'b1;
         lock_cnt_q   <= '0;
      end else begin
         last_owner_q <= last_owner_d;
         lock_cnt_q   <= lock_cnt_d;
      end
   end
`endif

   // Winner mux onto the RAM, grants, and read/error bookkeeping.
   always_comb begin
      accept    = m0_req | m1_req;
      w_we      = win ? m1_we    : m0_we;
      w_be      = win ? m1_be    : m0_be;
      w_addr    = win ? m1_addr  : m0_addr;
      w_wdata   = win ? m1_wdata : m0_wdata;
      in_range  = w_addr < ADDR_LIMIT;
      m0_gnt    = m0_req & ~win;
      m1_gnt    = m1_req & win;
      ram_addr  = w_addr[AW+1:2];
      ram_wdata = w_wdata;
      ram_wen   = (accept && w_we && in_range) ? w_be : 4'b0000;
      rd_pending_d = accept & ~w_we;
      rd_owner_d   = win;
      rd_oob_d     = ~in_range;
      err_d[0]     = accept & ~in_range & ~win;
      err_d[1]     = accept & ~in_range & win;
   end

   // Pending-read tag and out-of-range pulse registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_pending_q <= 1'b0;
         rd_owner_q   <= 1'b0;
         rd_oob_q     <= 1'b0;
         err_q        <= 2'b00;
      end else begin
         rd_pending_q <= rd_pending_d;
         rd_owner_q   <= rd_owner_d;
         rd_oob_q     <= rd_oob_d;
         err_q        <= err_d;
      end
   end

   // Return path: only the issuing port sees the registered read data.
   always_comb begin
      m0_rvalid = rd_pending_q & ~rd_owner_q;
      m1_rvalid = rd_pending_q & rd_owner_q;
      m0_rdata  = (m0_rvalid && !rd_oob_q) ? ram_rdata : 32'h0;
      m1_rdata  = (m1_rvalid && !rd_oob_q) ? ram_rdata : 32'h0;
      m0_err    = err_q[0];
      m1_err    = err_q[1];
   end

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed testbench for spram_arbiter with a behavioural SPRAM model.
module tb_spram_arbiter;
   localparam int WORDS    = 32768;
   localparam int AW       = 15;
   localparam int MAX_LOCK = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid, m0_err;
   logic [3:0]    m0_be;
   logic [31:0]   m0_addr, m0_wdata, m0_rdata;
   logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid, m1_err;
   logic [3:0]    m1_be;
   logic [31:0]   m1_addr, m1_wdata, m1_rdata;
   logic [AW-1:0] ram_addr;
   logic [3:0]    ram_wen;
   logic [31:0]   ram_wdata;
   logic [31:0]   ram_rdata;

   int checks = 0;
   int errors = 0;

   spram_arbiter #(.WORDS(WORDS), .AW(AW), .MAX_LOCK(MAX_LOCK)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_lock(m0_lock), .m0_gnt(m0_gnt),
      .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_gnt(m1_gnt),
      .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .ram_addr(ram_addr), .ram_wen(ram_wen), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   // SPRAM model: byte-enabled write, registered read.
   logic [31:0] mem [0:WORDS-1];
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (ram_wen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= mem[ram_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end else begin
         $display("ok   %s = %h", tag, got);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
      m0_req = req; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wdata;
   endtask

   task automatic drive1(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
      m1_req = req; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wdata;
   endtask

   initial begin
      for (int i = 0; i < WORDS; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
      reset = 1'b1;
      m0_lock = 1'b0;
      m1_lock = 1'b0;
      drive0(0, 0, 4'h0, 32'h0, 32'h0);
      drive1(0, 0, 4'h0, 32'h0, 32'h0);
      repeat (3) @(posedge clk);
      #2;
      // Reset values
      check("rst_m0_rvalid", m0_rvalid, 0);
      check("rst_m1_rvalid", m1_rvalid, 0);
      check("rst_m0_rdata", m0_rdata, 0);
      check("rst_m0_err", m0_err, 0);
      check("rst_m1_err", m1_err, 0);
      check("rst_ram_wen", ram_wen, 0);
      cyc();
      reset = 1'b0;

      // T1: write then read back through port 0
      cyc();
      drive0(1, 1, 4'hF, 32'h100, 32'hDEAD_BEEF);
      #1;
      check("t1_wr_gnt", m0_gnt, 1);
      check("t1_wr_wen", ram_wen, 4'hF);
      check("t1_wr_addr", ram_addr, 32'h40);
      cyc();
      drive0(1, 0, 4'h0, 32'h100, 32'h0);
      #1;
      check("t1_rd_gnt", m0_gnt, 1);
      check("t1_rd_wen", ram_wen, 0);
      check("t1_wr_no_rvalid", m0_rvalid, 0);
      cyc();
      drive0(0, 0, 4'h0, 32'h0, 32'h0);
      #1;
      check("t1_rvalid", m0_rvalid, 1);
      check("t1_rdata", m0_rdata, 32'hDEAD_BEEF);
      check("t1_m1_rvalid", m1_rvalid, 0);

      // Last in-range word with partial byte enables
      cyc();
      drive0(1, 1, 4'h3, 32'h1FFFC, 32'h1234_5678);
      #1;
      check("top_wr_wen", ram_wen, 4'h3);
      cyc();
      drive0(1, 0, 4'h0, 32'h1FFFC, 32'h0);
      #1;
      check("top_no_err", m0_err, 0);
      cyc();
      drive0(0, 0, 4'h0, 32'h0, 32'h0);
      #1;
      check("top_rdata", m0_rdata, 32'hA5A5_5678);

      // T4: out-of-range write and read on port 1
      cyc();
      drive1(1, 1, 4'hF, 32'h20000, 32'h5);
      #1;
      check("t4_wr_gnt", m1_gnt, 1);
      check("t4_wr_wen", ram_wen, 0);
      cyc();
      drive1(0, 0, 4'h0, 32'h0, 32'h0);
      #1;
      check("t4_wr_err", m1_err, 1);
      check("t4_m0_err", m0_err, 0);
      check("t4_wr_no_rvalid", m1_rvalid, 0);
      cyc();
      drive1(1, 0, 4'h0, 32'h20000, 32'h0);
      #1;
      check("t4_err_pulse_end", m1_err, 0);
      cyc();
      drive1(0, 0, 4'h0, 32'h0, 32'h0);
      #1;
      check("t4_rd_rvalid", m1_rvalid, 1);
      check("t4_rd_rdata", m1_rdata, 0);
      check("t4_rd_err", m1_err, 1);
      cyc();
      drive0(1, 0, 4'h0, 32'h0, 32'h0);
      cyc();
      drive0(0, 0, 4'h0, 32'h0, 32'h0);
      #1;
      check("t4_word0_intact", m0_rdata, 32'hA5A5_0000);

      // Preload a word for port 1 (leaves port 1 as last owner)
      cyc();
      drive1(1, 1, 4'hF, 32'h200, 32'hCAFE_F00D);
      cyc();
      drive1(0, 0, 4'h0, 32'h0, 32'h0);

`ifdef SPRAM_ARB_FIXED_PRIO_EN
      // T6: fixed priority, port 1 locked but never served
      cyc();
      m1_lock = 1'b1;
      drive0(1, 0, 4'h0, 32'h100, 32'h0);
      drive1(1, 0, 4'h0, 32'h200, 32'h0);
      for (int i = 0; i < 8; i++) begin
         #1;
         check($sformatf("t6_m0_gnt_%0d", i), m0_gnt, 1);
         check($sformatf("t6_m1_gnt_%0d", i), m1_gnt, 0);
         cyc();
      end
      m1_lock = 1'b0;
      drive0(0, 0, 4'h0, 32'h0, 32'h0);
      drive1(0, 0, 4'h0, 32'h0, 32'h0);
`else
      // T2: both ports reading continuously, grants alternate starting at m0
      cyc();
      drive0(1, 0, 4'h0, 32'h100, 32'h0);
      drive1(1, 0, 4'h0, 32'h200, 32'h0);
      for (int i = 0; i < 6; i++) begin
         #1;
         check($sformatf("t2_m0_gnt_%0d", i), m0_gnt, (i % 2 == 0));
         check($sformatf("t2_m1_gnt_%0d", i), m1_gnt, (i % 2 == 1));
         if (i > 0) begin
            if (i % 2 == 1) begin
               check($sformatf("t2_m0_rvalid_%0d", i), m0_rvalid, 1);
               check($sformatf("t2_m0_rdata_%0d", i), m0_rdata, 32'hDEAD_BEEF);
               check($sformatf("t2_m1_quiet_%0d", i), m1_rvalid, 0);
            end else begin
               check($sformatf("t2_m1_rvalid_%0d", i), m1_rvalid, 1);
               check($sformatf("t2_m1_rdata_%0d", i), m1_rdata, 32'hCAFE_F00D);
               check($sformatf("t2_m0_quiet_%0d", i), m0_rvalid, 0);
            end
         end
         cyc();
      end
      drive0(0, 0, 4'h0, 32'h0, 32'h0);
      drive1(0, 0, 4'h0, 32'h0, 32'h0);
      #1;
      check("t2_last_m1_rvalid", m1_rvalid, 1);
      check("t2_last_m1_rdata", m1_rdata, 32'hCAFE_F00D);

      // Make port 0 the last owner so the locked run starts on a round-robin turn
      cyc();
      drive0(1, 0, 4'h0, 32'h100, 32'h0);
      #1;
      check("t3_prep_gnt", m0_gnt, 1);
      cyc();
      // T3: port 1 locked, both requesting: 16 grants to m1, then m0
      m1_lock = 1'b1;
      drive1(1, 0, 4'h0, 32'h200, 32'h0);
      for (int i = 0; i <= MAX_LOCK; i++) begin
         #1;
         check($sformatf("t3_m1_gnt_%0d", i), m1_gnt, (i < MAX_LOCK));
         check($sformatf("t3_m0_gnt_%0d", i), m0_gnt, (i >= MAX_LOCK));
         cyc();
      end
      m1_lock = 1'b0;
      drive0(0, 0, 4'h0, 32'h0, 32'h0);
      drive1(0, 0, 4'h0, 32'h0, 32'h0);
`endif

      // T5: reset while a read is pending
      cyc();
      drive0(1, 0, 4'h0, 32'h100, 32'h0);
      #1;
      check("t5_rd_gnt", m0_gnt, 1);
      cyc();
      drive0(0, 0, 4'h0, 32'h0, 32'h0);
      reset = 1'b1;
      #1;
      check("t5_rvalid_in_reset", m0_rvalid, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("t5_rvalid_after_reset", m0_rvalid, 0);
      cyc();
      check("t5_rvalid_later", m0_rvalid, 0);
      drive0(1, 0, 4'h0, 32'h100, 32'h0);
      drive1(1, 0, 4'h0, 32'h200, 32'h0);
      #1;
      check("t5_tie_m0_gnt", m0_gnt, 1);
      check("t5_tie_m1_gnt", m1_gnt, 0);
      cyc();
      drive0(0, 0, 4'h0, 32'h0, 32'h0);
      drive1(0, 0, 4'h0, 32'h0, 32'h0);
      #1;
      check("t5_tie_rvalid", m0_rvalid, 1);
      check("t5_tie_rdata", m0_rdata, 32'hDEAD_BEEF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
